// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path:
//   - rx_state_e     : receiver FSM state encoding
//   - PAR_NONE/ODD/EVEN : ParityType encodings (2'b11 decodes as "none")
//   - parity_enabled : true when a parity bit is present in the frame
//   - parity_error   : parity check on XOR(data bits, parity bit)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

    // xor_all is the XOR of every data bit and the received parity bit.
    function automatic logic parity_error(input logic [1:0] mode, input logic xor_all);
        logic err;
        case (mode)
            PAR_ODD:  err = ~xor_all;
            PAR_EVEN: err = xor_all;
            default:  err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// SYNC_STAGES-deep flop chain bringing an asynchronous serial line into the
// clk_i domain. Resets to 1 so an idle (high) line never looks like a start
// bit while coming out of reset. Shared with the transmitter loopback path.
//
// Ports:
//   clk_i   in  system clock
//   rst_ni  in  asynchronous active-low reset
//   async_i in  asynchronous serial line
//   sync_o  out synchronised line (SYNC_STAGES cycles of latency)
// ---------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
// Oversampled UART receiver. Deserialises DATA_W data bits (LSB first), an
// optional parity bit and one or two stop bits, then presents the word with
// parity/framing status on a valid/ready interface. A frame completing while
// the previous word is still unaccepted is dropped and flagged by a one-cycle
// OverrunErr pulse. A framing error on an all-zero word is treated as a line
// break: the receiver parks until the line returns high.
//
// Build option:
//   RX_MAJORITY_VOTE_EN  each bit decision is the 2-of-3 vote of three
//                        consecutive oversampling ticks around mid-bit;
//                        undefined = single sample at mid-bit.
//
// Ports:
//   Clk         in   system clock (posedge)
//   ResetN      in   asynchronous active-low reset
//   BaudTick    in   oversampling enable, OVERSAMPLE pulses per bit
//   RxIn        in   asynchronous serial line, idle high
//   ParityType  in   00 none, 01 odd, 10 even, 11 none
//   StopBits    in   0 = one stop bit, 1 = two stop bits
//   DataOut     out  received word
//   DataValid   out  DataOut/ParityErr/FrameErr valid
//   DataReady   in   consumer accepts when DataValid && DataReady
//   ParityErr   out  parity mismatch for the word on DataOut
//   FrameErr    out  a stop bit was sampled low for the word on DataOut
//   OverrunErr  out  one-cycle pulse when a completed frame is dropped
// ---------------------------------------------------------------------------
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              BaudTick,
    input  logic              RxIn,
    input  logic [1:0]        ParityType,
    input  logic              StopBits,
    output logic [DATA_W-1:0] DataOut,
    output logic              DataValid,
    input  logic              DataReady,
    output logic              ParityErr,
    output logic              FrameErr,
    output logic              OverrunErr
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_W);

`ifdef RX_MAJORITY_VOTE_EN
    // The counter runs one tick ahead of the single-sample build, so the vote
    // window (mid-1, mid, mid+1) closes on the same tick where the
    // single-sample build decides. Bit boundaries and latency are unchanged;
    // mid+1 of a data bit is counter value 0 after the natural wrap.
    localparam logic [CNT_W-1:0] START_PT = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] BIT_PT   = '0;
    localparam logic [CNT_W-1:0] CNT_CLR  = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] START_PT = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_PT   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_CLR  = '0;
`endif

    logic rx_sync;
    logic bit_val;

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [1:0]        par_mode_q, par_mode_d;
    logic              two_stop_q, two_stop_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              perr_out_q, perr_out_d;
    logic              ferr_out_q, ferr_out_d;
    logic              ovr_q, ovr_d;

    logic              start_pt;
    logic              bit_pt;
    logic              frame_done;
    logic              frame_ferr;

    // ---- line synchroniser ----
    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (Clk),
        .rst_ni (ResetN),
        .async_i(RxIn),
        .sync_o (rx_sync)
    );

    // ---- bit decision ----
`ifdef RX_MAJORITY_VOTE_EN
    // Line values seen on the two previous ticks; combined with the current
    // tick they form the three-sample vote.
    logic [1:0] hist_q;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            hist_q <= 2'b11;
        end else if (BaudTick) begin
            hist_q <= {hist_q[0], rx_sync};
        end
    end

    assign bit_val = (hist_q[1] & hist_q[0]) |
                     (hist_q[1] & rx_sync)   |
                     (hist_q[0] & rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    assign start_pt = BaudTick && (cnt_q == START_PT);
    assign bit_pt   = BaudTick && (cnt_q == BIT_PT);

    // ---- receive FSM: next state ----
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        par_mode_d = par_mode_q;
        two_stop_d = two_stop_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;
        frame_ferr = ferr_q;

        if (BaudTick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (BaudTick && !rx_sync) begin
                    cnt_d   = CNT_CLR;
                    state_d = START;
                end
            end

            START: begin
                if (start_pt) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        // Frame format is frozen for the rest of this frame.
                        par_mode_d = ParityType;
                        two_stop_d = StopBits;
                        cnt_d      = CNT_CLR;
                        bitcnt_d   = '0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        state_d    = DATA;
                    end
                end
            end

            DATA: begin
                if (bit_pt) begin
                    shift_d = {bit_val, shift_q[DATA_W-1:1]};
                    if (bitcnt_q == BIT_W'(DATA_W - 1)) begin
                        bitcnt_d = '0;
                        state_d  = parity_enabled(par_mode_q) ? PARITY : STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + BIT_W'(1);
                    end
                end
            end

            PARITY: begin
                if (bit_pt) begin
                    perr_d  = parity_error(par_mode_q, (^shift_q) ^ bit_val);
                    state_d = STOP;
                end
            end

            STOP: begin
                if (bit_pt) begin
                    frame_ferr = ferr_q | ~bit_val;
                    ferr_d     = frame_ferr;
                    if (two_stop_q && (bitcnt_q == '0)) begin
                        bitcnt_d = BIT_W'(1);
                    end else begin
                        frame_done = 1'b1;
                        // Low stop with an all-zero word is a break condition.
                        state_d = (frame_ferr && (shift_q == '0)) ? BREAK : IDLE;
                    end
                end
            end

            BREAK: begin
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---- output holding register ----
    always_comb begin
        dout_d     = dout_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = 1'b0;

        if (valid_q && DataReady) begin
            valid_d = 1'b0;
        end

        if (frame_done) begin
            // A handshake in the same cycle frees the register for the new word.
            if (!valid_q || DataReady) begin
                dout_d     = shift_q;
                perr_out_d = perr_q;
                ferr_out_d = frame_ferr;
                valid_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            par_mode_q <= PAR_NONE;
            two_stop_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            par_mode_q <= par_mode_d;
            two_stop_q <= two_stop_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign DataOut    = dout_q;
    assign DataValid  = valid_q;
    assign ParityErr  = perr_out_q;
    assign FrameErr   = ferr_out_q;
    assign OverrunErr = ovr_q;

endmodule
